// File: rtl/paddle_controller.sv
// Pong paddle: manual joystick or auto ball tracking, stepped motion with
// a prescaler that shortens as steps accumulate, and a registered pixel draw.
module paddle_controller #(
  parameter logic [2:0] COLOR        = 3'b111,
  parameter int unsigned PADDLE_W     = 4,
  parameter int unsigned PADDLE_H     = 40,
  parameter int unsigned START_X      = 5,
  parameter int unsigned START_Y      = 100,
  parameter int unsigned LIMIT_Y_MIN  = 5,
  parameter int unsigned LIMIT_Y_MAX  = 475,
  parameter int unsigned SPEED_GROUND = 5,
  parameter int unsigned MAX_SPEED    = 2,
  parameter int unsigned ACCEL_STEP   = 40,
  parameter int unsigned AI_DEADBAND  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mode,
  input  logic       i_control_up,
  input  logic       i_control_down,
  input  logic       i_freeze,
  input  logic [9:0] i_ball_y,
  input  logic [9:0] i_row,
  input  logic [9:0] i_col,
  output logic [2:0] o_rgb,
  output logic [9:0] o_pos_x,
  output logic [9:0] o_pos_y,
  output logic [7:0] o_size_x,
  output logic [7:0] o_size_y,
  output logic [7:0] o_speed,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10} state_t;

  state_t      r_state;
  state_t      w_req;
  logic [9:0]  r_pos_y;
  logic [7:0]  r_speed;
  logic [7:0]  r_timer;
  logic [7:0]  r_accel;
  logic [2:0]  r_rgb;

  // 11-bit sums keep pos/ball arithmetic free of wrap
  logic [10:0] w_pos11;
  logic [10:0] w_centre;
  logic [10:0] w_bottom;
  logic [10:0] w_ball11;
  logic [10:0] w_row11;
  logic [10:0] w_col11;
  logic        w_tick;
  logic        w_exec;

  assign w_pos11  = {1'b0, r_pos_y};
  assign w_centre = w_pos11 + 11'(PADDLE_H / 2);
  assign w_bottom = w_pos11 + 11'(PADDLE_H);
  assign w_ball11 = {1'b0, i_ball_y};
  assign w_row11  = {1'b0, i_row};
  assign w_col11  = {1'b0, i_col};
  assign w_tick   = (r_timer == r_speed - 8'd1);
  // A step only counts when the paddle actually moved
  assign w_exec   = w_tick &&
                    (((r_state == UP)   && (r_pos_y > 10'(LIMIT_Y_MIN))) ||
                     ((r_state == DOWN) && (w_bottom < 11'(LIMIT_Y_MAX))));

  // Motion request from joystick or ball tracker; freeze overrides both
  always_comb begin
    w_req = IDLE;
    if (i_freeze) begin
      w_req = IDLE;
    end else if (!i_mode) begin
      if (i_control_up && !i_control_down)      w_req = UP;
      else if (i_control_down && !i_control_up) w_req = DOWN;
    end else begin
      if (w_ball11 + 11'(AI_DEADBAND) < w_centre)      w_req = UP;
      else if (w_ball11 > w_centre + 11'(AI_DEADBAND)) w_req = DOWN;
    end
  end

  // Motion FSM: prescaled stepping with acceleration, restarted on any change
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_pos_y <= 10'(START_Y);
      r_speed <= 8'(SPEED_GROUND);
      r_timer <= 8'd0;
      r_accel <= 8'd0;
    end else if ((w_req != r_state) || (w_req == IDLE)) begin
      r_state <= w_req;
      r_speed <= 8'(SPEED_GROUND);
      r_timer <= 8'd0;
      r_accel <= 8'd0;
    end else if (w_tick) begin
      r_timer <= 8'd0;
      if (w_exec) begin
        if (r_state == UP) r_pos_y <= r_pos_y - 10'd1;
        else               r_pos_y <= r_pos_y + 10'd1;
        if (r_accel == 8'(ACCEL_STEP - 1)) begin
          r_accel <= 8'd0;
          if (r_speed > 8'(MAX_SPEED)) r_speed <= r_speed - 8'd1;
        end else begin
          r_accel <= r_accel + 8'd1;
        end
      end
    end else begin
      r_timer <= r_timer + 8'd1;
    end
  end

  // Registered pixel colour: inside the paddle rectangle or black
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rgb <= 3'b000;
    end else if ((w_col11 >= 11'(START_X)) && (w_col11 < 11'(START_X) + 11'(PADDLE_W)) &&
                 (w_row11 >= w_pos11) && (w_row11 < w_bottom)) begin
      r_rgb <= COLOR;
    end else begin
      r_rgb <= 3'b000;
    end
  end

  assign o_rgb    = r_rgb;
  assign o_pos_x  = 10'(START_X);
  assign o_pos_y  = r_pos_y;
  assign o_size_x = 8'(PADDLE_W);
  assign o_size_y = 8'(PADDLE_H);
  assign o_speed  = r_speed;
  assign o_state  = r_state;

endmodule

// File: doc/paddle_controller.md
# paddle_controller

Parametrised paddle block for the Pong game. It supports manual joystick control and an automatic ball-tracking mode. A three-state motion FSM with a step prescaler and acceleration moves the paddle. A registered pixel-draw output feeds the VGA compositor. It sits beside the ball block in the GUI layer; the collision logic consumes its position, size and speed outputs.

## Interface
- COLOR, 3'b111, RGB drawn inside the paddle rectangle
- PADDLE_W, 4, paddle width in pixels (1..255)
- PADDLE_H, 40, paddle height in pixels (1..255)
- START_X, 5, fixed x position
- START_Y, 100, y position after reset
- LIMIT_Y_MIN, 5, smallest allowed pos_y
- LIMIT_Y_MAX, 475, exclusive bottom limit for pos_y+PADDLE_H
- SPEED_GROUND, 5, step period in clocks when motion starts (2..255)
- MAX_SPEED, 2, shortest step period (1..SPEED_GROUND)
- ACCEL_STEP, 40, number of executed steps per period decrement (1..255)
- AI_DEADBAND, 4, auto-mode tolerance in pixels around the paddle centre
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- mode  in  1  0 = manual, 1 = auto-track
- control_up  in  1  1 = joystick up (manual mode)
- control_down  in  1  1 = joystick down (manual mode)
- freeze  in  1  1 = hold position; forces the request to idle
- ball_y  in  10  ball top y, used in auto mode
- row  in  10  pixel row being drawn
- col  in  10  pixel column being drawn
- rgb  out  3  registered pixel colour
- pos_x  out  10  paddle left x
- pos_y  out  10  paddle top y
- size_x  out  8  PADDLE_W
- size_y  out  8  PADDLE_H
- speed  out  8  current step period in clocks
- state  out  2  00 IDLE, 01 UP, 10 DOWN

## Operation
- Reset (asynchronous) sets these values immediately:
  - pos_x=START_X, pos_y=START_Y, size_x=PADDLE_W, size_y=PADDLE_H
  - speed=SPEED_GROUND, state=IDLE, rgb=0
  - internal timer=0, accel_cnt=0
- The request is computed combinationally each cycle:
  - freeze=1 gives IDLE, regardless of mode.
  - Manual: UP if control_up & ~control_down; DOWN if control_down & ~control_up; otherwise IDLE (both or neither pressed).
  - Auto: centre = pos_y + PADDLE_H/2. UP if ball_y + AI_DEADBAND < centre; DOWN if ball_y > centre + AI_DEADBAND; otherwise IDLE.
  - All sums use 11-bit arithmetic, so there is no wrap.
- FSM:
  - Next state is the request.
  - On entry to IDLE, or on any state change (including a direct UP to DOWN reversal), set timer=0, accel_cnt=0, speed=SPEED_GROUND.
  - In UP or DOWN with no state change, each edge does one of two things:
    - If timer==speed-1: timer=0 and a step is attempted.
    - Otherwise: timer increments by 1.
- Step:
  - UP moves pos_y down by 1 only if pos_y > LIMIT_Y_MIN.
  - DOWN moves pos_y up by 1 only if pos_y+PADDLE_H < LIMIT_Y_MAX.
  - A blocked step changes nothing and does not count toward acceleration.
- Acceleration, on each executed step:
  - If accel_cnt==ACCEL_STEP-1: accel_cnt=0, and speed decrements by 1 if speed > MAX_SPEED.
  - Otherwise: accel_cnt increments by 1.
- A mode switch mid-motion only changes the request; the FSM rules above apply unchanged.
- Draw: rgb is registered. On each edge, rgb=COLOR if pos_x ≤ col < pos_x+PADDLE_W and pos_y ≤ row < pos_y+PADDLE_H; otherwise rgb=0. The comparison uses the current-cycle pos values and 11-bit sums.

## Timing
- Request to state: 1 clock.
- First step: 5 edges after the entry edge with default parameters; in general SPEED_GROUND edges.
- Steady step period equals the speed output.
- With defaults, speed becomes 4 after 40 executed steps, 3 after 80, and 2 after 120, then holds at 2.
- pos_y changes on the step edge and is visible the same cycle as state/speed updates.
- rgb latency is 1 clock from row/col.
- Reset asserted mid-motion takes effect without a clock edge. After release, the first edge samples the request.

## Test plan
- Async reset during DOWN motion: all outputs return to reset values before the next edge (pos_y=100, speed=5, state=0, rgb=0).
- Manual up held from reset:
  - state=UP 1 clock after control_up rises.
  - pos_y=99 5 edges after entry.
  - speed=4 after 40 steps and =2 after 120 steps.
  - Releasing control_up gives IDLE with speed=5.
- Limits:
  - Holding up stops at pos_y=5.
  - Holding down stops at pos_y=435.
  - Blocked steps leave speed unchanged.
- Simultaneous control_up=control_down=1, and separately freeze=1 while in UP: state goes to IDLE, pos_y is held, speed returns to 5.
- Auto mode with pos_y=100 and ball_y=300: state=DOWN until pos_y=276, then IDLE. Moving ball_y to 0 reverses to UP with speed reset to 5.
- Draw with pos (5,100):
  - row=100, col=5 gives rgb=111 on the next edge.
  - col=9 gives 000; row=140 gives 000; row=139, col=8 gives 111.
